// File: rtl/mem_arb_pkg.sv
// Shared core types for the IFU/LSU memory arbiter: FSM states, owner encoding, bus widths.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;
  localparam int MASK_W = `DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;
endpackage

// File: rtl/mem_arb_if.sv
// Handshake bundle tying the arbiter to the IFU, the LSU and the memory port.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic              i_ifu_req_valid;
  logic              o_ifu_req_ready;
  logic [ADDR_W-1:0] i_ifu_req_addr;
  logic              o_ifu_resp_valid;
  logic              i_ifu_resp_ready;
  logic [DATA_W-1:0] o_ifu_resp_data;
  logic              o_ifu_resp_err;

  logic              i_lsu_req_valid;
  logic              o_lsu_req_ready;
  logic [ADDR_W-1:0] i_lsu_req_addr;
  logic              i_lsu_req_wr_en;
  logic [DATA_W-1:0] i_lsu_req_wr_data;
  logic [MASK_W-1:0] i_lsu_req_wr_mask;
  logic              o_lsu_resp_valid;
  logic              i_lsu_resp_ready;
  logic [DATA_W-1:0] o_lsu_resp_data;
  logic              o_lsu_resp_err;

  logic              o_mem_req_valid;
  logic              i_mem_req_ready;
  logic [ADDR_W-1:0] o_mem_req_addr;
  logic              o_mem_req_wr_en;
  logic [DATA_W-1:0] o_mem_req_wr_data;
  logic [MASK_W-1:0] o_mem_req_wr_mask;
  logic              i_mem_resp_valid;
  logic              o_mem_resp_ready;
  logic [DATA_W-1:0] i_mem_resp_data;
  logic              i_mem_resp_err;

  logic              o_arb_busy;

  modport slave (
    input  i_ifu_req_valid, i_ifu_req_addr, i_ifu_resp_ready,
    input  i_lsu_req_valid, i_lsu_req_addr, i_lsu_req_wr_en, i_lsu_req_wr_data,
    input  i_lsu_req_wr_mask, i_lsu_resp_ready,
    input  i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data, i_mem_resp_err,
    output o_ifu_req_ready, o_ifu_resp_valid, o_ifu_resp_data, o_ifu_resp_err,
    output o_lsu_req_ready, o_lsu_resp_valid, o_lsu_resp_data, o_lsu_resp_err,
    output o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_data,
    output o_mem_req_wr_mask, o_mem_resp_ready, o_arb_busy
  );

  modport master (
    output i_ifu_req_valid, i_ifu_req_addr, i_ifu_resp_ready,
    output i_lsu_req_valid, i_lsu_req_addr, i_lsu_req_wr_en, i_lsu_req_wr_data,
    output i_lsu_req_wr_mask, i_lsu_resp_ready,
    output i_mem_req_ready, i_mem_resp_valid, i_mem_resp_data, i_mem_resp_err,
    input  o_ifu_req_ready, o_ifu_resp_valid, o_ifu_resp_data, o_ifu_resp_err,
    input  o_lsu_req_ready, o_lsu_resp_valid, o_lsu_resp_data, o_lsu_resp_err,
    input  o_mem_req_valid, o_mem_req_addr, o_mem_req_wr_en, o_mem_req_wr_data,
    input  o_mem_req_wr_mask, o_mem_resp_ready, o_arb_busy
  );
endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of back-to-back LSU grants taken while the IFU was waiting.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst || clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sat = (cnt == CNT_MAX);
endmodule

// File: rtl/mem_arb.sv
// Two-requester memory arbiter: LSU has priority, IFU forced through after STARVE_MAX LSU wins.
//   state  | meaning
//   S_IDLE | pick a winner, latch its payload
//   S_REQ  | present latched request to memory
//   S_RESP | wait for memory response, latch data/err
//   S_DONE | hand response to the owner
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic     i_sys_clk,
  input  logic     i_sys_rst,
  mem_arb_if.slave bus
);
  arb_state_e        state, next_state;
  arb_owner_e        owner;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wr_en;
  logic [DATA_W-1:0] req_wr_data;
  logic [MASK_W-1:0] req_wr_mask;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              starve_sat, lsu_win, ifu_win, cnt_inc, cnt_clr;

  assign cnt_inc = lsu_win && bus.i_ifu_req_valid;
  assign cnt_clr = ifu_win || (lsu_win && !bus.i_ifu_req_valid);

  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .inc       (cnt_inc),
    .clr       (cnt_clr),
    .sat       (starve_sat)
  );

  // Every valid/ready is forced low while reset is held, even mid-transaction.
  always_comb begin
    next_state           = state;
    lsu_win              = 1'b0;
    ifu_win              = 1'b0;
    bus.o_ifu_req_ready  = 1'b0;
    bus.o_lsu_req_ready  = 1'b0;
    bus.o_mem_req_valid  = 1'b0;
    bus.o_mem_resp_ready = 1'b0;
    bus.o_ifu_resp_valid = 1'b0;
    bus.o_lsu_resp_valid = 1'b0;
    if (!i_sys_rst) begin
      case (state)
        S_IDLE: begin
          lsu_win = bus.i_lsu_req_valid && !(starve_sat && bus.i_ifu_req_valid);
          ifu_win = bus.i_ifu_req_valid && !lsu_win;
          bus.o_lsu_req_ready = lsu_win;
          bus.o_ifu_req_ready = ifu_win;
          if (lsu_win || ifu_win) next_state = S_REQ;
        end
        S_REQ: begin
          bus.o_mem_req_valid = 1'b1;
          if (bus.i_mem_req_ready) next_state = S_RESP;
        end
        S_RESP: begin
          bus.o_mem_resp_ready = 1'b1;
          if (bus.i_mem_resp_valid) next_state = S_DONE;
        end
        S_DONE: begin
          bus.o_ifu_resp_valid = (owner == OWN_IFU);
          bus.o_lsu_resp_valid = (owner == OWN_LSU);
          if ((owner == OWN_IFU && bus.i_ifu_resp_ready) ||
              (owner == OWN_LSU && bus.i_lsu_resp_ready)) next_state = S_IDLE;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state       <= S_IDLE;
      owner       <= OWN_IFU;
      req_addr    <= '0;
      req_wr_en   <= 1'b0;
      req_wr_data <= '0;
      req_wr_mask <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      state <= next_state;
      if (lsu_win) begin
        owner       <= OWN_LSU;
        req_addr    <= bus.i_lsu_req_addr;
        req_wr_en   <= bus.i_lsu_req_wr_en;
        req_wr_data <= bus.i_lsu_req_wr_data;
        req_wr_mask <= bus.i_lsu_req_wr_mask;
      end else if (ifu_win) begin
        owner       <= OWN_IFU;
        req_addr    <= bus.i_ifu_req_addr;
        req_wr_en   <= 1'b0;
        req_wr_data <= '0;
        req_wr_mask <= '0;
      end
      // Stores report zero data back to the LSU regardless of what memory drives.
      if (state == S_RESP && bus.i_mem_resp_valid) begin
        resp_data <= (owner == OWN_LSU && req_wr_en) ? '0 : bus.i_mem_resp_data;
        resp_err  <= bus.i_mem_resp_err;
      end
    end
  end

  assign bus.o_mem_req_addr    = req_addr;
  assign bus.o_mem_req_wr_en   = req_wr_en;
  assign bus.o_mem_req_wr_data = req_wr_data;
  assign bus.o_mem_req_wr_mask = req_wr_mask;
  assign bus.o_ifu_resp_data   = resp_data;
  assign bus.o_ifu_resp_err    = resp_err;
  assign bus.o_lsu_resp_data   = resp_data;
  assign bus.o_lsu_resp_err    = resp_err;
  assign bus.o_arb_busy        = (state != S_IDLE) && !i_sys_rst;
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the consecutive LSU grants allowed while IFU waits before IFU is forced to win.
REQ-002 Widths SHALL use the shared `ADDR_WIDTH and `DATA_WIDTH macros; MASK_W = `DATA_WIDTH/8.
REQ-003 i_sys_clk  in  1  sole clock, all state updates on posedge.
REQ-004 i_sys_rst  in  1  reset, synchronous, active-high.
REQ-005 i_ifu_req_valid / o_ifu_req_ready  in/out  1/1  IFU fetch request handshake.
REQ-006 i_ifu_req_addr  in  `ADDR_WIDTH  fetch address.
REQ-007 o_ifu_resp_valid / i_ifu_resp_ready  out/in  1/1  IFU response handshake.
REQ-008 o_ifu_resp_data / o_ifu_resp_err  out  `DATA_WIDTH/1  fetched word and error flag.
REQ-009 i_lsu_req_valid / o_lsu_req_ready  in/out  1/1  LSU request handshake.
REQ-010 i_lsu_req_addr / i_lsu_req_wr_en  in  `ADDR_WIDTH/1  data address, 1 = store.
REQ-011 i_lsu_req_wr_data / i_lsu_req_wr_mask  in  `DATA_WIDTH/MASK_W  store data and byte mask.
REQ-012 o_lsu_resp_valid / i_lsu_resp_ready  out/in  1/1  LSU response handshake.
REQ-013 o_lsu_resp_data / o_lsu_resp_err  out  `DATA_WIDTH/1  load data (0 for store) and error flag.
REQ-014 o_mem_req_valid / i_mem_req_ready  out/in  1/1  memory request handshake.
REQ-015 o_mem_req_addr / o_mem_req_wr_en / o_mem_req_wr_data / o_mem_req_wr_mask  out  `ADDR_WIDTH/1/`DATA_WIDTH/MASK_W  registered request payload.
REQ-016 i_mem_resp_valid / o_mem_resp_ready  in/out  1/1  memory response handshake.
REQ-017 i_mem_resp_data / i_mem_resp_err  in  `DATA_WIDTH/1  memory response payload.
REQ-018 o_arb_busy  out  1  high whenever state is not S_IDLE.

Function
REQ-019 FSM states SHALL be S_IDLE, S_REQ, S_RESP, S_DONE; exactly one transaction outstanding.
REQ-020 Handshake SHALL complete on the cycle where valid and ready are both high; valid, once raised, holds with stable payload until accepted.
REQ-021 In S_IDLE the winner SHALL be LSU if LSU valid and not starving IFU, else IFU if valid; only the winner sees req_ready=1.
REQ-022 Starving IFU SHALL mean starve_cnt == STARVE_MAX while i_ifu_req_valid=1.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_MAX) on an LSU grant with i_ifu_req_valid=1, clear on an IFU grant or on an LSU grant with i_ifu_req_valid=0.
REQ-024 On grant, payload and owner SHALL be latched (IFU: wr_en=0, mask=0, data=0) and state -> S_REQ next cycle.
REQ-025 In S_REQ o_mem_req_valid=1 from latched payload; on i_mem_req_ready -> S_RESP.
REQ-026 In S_RESP o_mem_resp_ready=1; on i_mem_resp_valid, data/err latched -> S_DONE; a response arriving in other states is not accepted.
REQ-027 In S_DONE only the owner's resp_valid=1 with latched data/err; on its resp_ready -> S_IDLE.
REQ-028 Minimum latency SHALL be: grant cycle N, mem req valid N+1, resp accepted N+2, requester resp_valid N+3; no new grant before the cycle after the S_DONE handshake.
REQ-029 Both req_ready outputs SHALL be 0 outside S_IDLE; a requester dropping valid before grant is legal and loses nothing.
REQ-030 i_mem_resp_err SHALL pass through unmodified; it SHALL NOT alter sequencing.

Reset
REQ-031 While i_sys_rst=1: state S_IDLE, starve_cnt 0, owner IFU, all latched payload 0, every valid/ready output 0, o_arb_busy 0.
REQ-032 Reset asserted mid-transaction SHALL abandon it without any response; the memory side is reset by the same signal.
REQ-033 First grant SHALL be possible in the first cycle after i_sys_rst deasserts.

Structure
REQ-034 The state enum and the owner encoding (OWN_IFU=0, OWN_LSU=1) SHALL live in the shared core package.
REQ-035 The starvation counter SHALL be a sub-module arb_starve_cnt (inc, clr, sat flag); the rest stays flat.

Verification
REQ-036 IFU-only fetch 0x8000_0000, mem ready immediate, data 0x0000_0013 -> o_ifu_resp_valid at N+3 with 0x13, err 0.
REQ-037 IFU and LSU valid together in S_IDLE, LSU store 0x8000_1000 data 0xDEADBEEF mask 0xF -> LSU granted first, mem wr_en=1 mask 0xF, IFU granted after LSU S_DONE handshake.
REQ-038 LSU valid continuously with IFU waiting, STARVE_MAX=4 -> 4 LSU grants, then IFU grant, starve_cnt 0.
REQ-039 i_mem_req_ready held 0 for 5 cycles, i_ifu_resp_ready held 0 for 3 cycles -> payload stable throughout, no second grant, o_arb_busy=1.
REQ-040 i_sys_rst pulsed during S_RESP -> next cycle all outputs 0, state S_IDLE, no response to owner; fresh request served normally.
REQ-041 Memory returns err=1 on LSU load -> o_lsu_resp_err=1 with returned data, FSM returns to S_IDLE normally.
